// File: rtl/router_pkg.sv
// Shared types and sizing for the router input buffer.
package router_pkg;
  localparam int ROUTER_BUF_DEPTH = 64;
  localparam int CNT_W            = 7;
  localparam int FLIT_W           = 32;
  localparam int ROUTER_AF_THRESH = 56;

  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/router_buf_mem.sv
// Flit storage: one synchronous write port, one asynchronous read port.
module router_buf_mem #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  // Contents are don't-care after reset, so the array carries no reset.
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/router_input_buffer.sv
// FWFT flit FIFO for one router input port with occupancy and backpressure flags.
// Optional statistics (peak_count, stall_cycles) under ROUTER_BUF_STATS_EN.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int DATA_W    = FLIT_W,
  parameter int DEPTH     = ROUTER_BUF_DEPTH,
  parameter int AF_THRESH = ROUTER_AF_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              empty,
`ifdef ROUTER_BUF_STATS_EN
  output logic [CNT_W-1:0]  peak_count,
  output logic [31:0]       stall_cycles,
`endif
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data;
  logic              push, pop;

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : rd_data;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  router_buf_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (push & !flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

`ifdef ROUTER_BUF_STATS_EN
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [31:0]      stall_q, stall_d;

  // Peak tracks the next count so it already covers the value shown on count.
  always_comb begin
    peak_d  = peak_q;
    stall_d = stall_q;
    if (flush) begin
      peak_d  = '0;
      stall_d = '0;
    end else begin
      if (count_d > peak_q) peak_d = count_d;
      if (in_valid && !in_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      peak_q  <= peak_d;
      stall_q <= stall_d;
    end
  end

  assign peak_count   = peak_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_router_input_buffer.sv
// Directed bench for router_input_buffer with a queue-based reference model.
module tb_router_input_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [6:0]  count;
  logic        almost_full, empty, full;
`ifdef ROUTER_BUF_STATS_EN
  logic [6:0]  peak_count;
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_input_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .empty(empty),
`ifdef ROUTER_BUF_STATS_EN
    .peak_count(peak_count), .stall_cycles(stall_cycles),
`endif
    .full(full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the buffer is just an ordered list of flits.
  logic [31:0] mq[$];
  int          m_peak = 0;
  longint      m_stall = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_peak  = 0;
      m_stall = 0;
    end else if (flush) begin
      mq.delete();
      m_peak  = 0;
      m_stall = 0;
    end else begin
      automatic bit acc = in_valid && (mq.size() < 64);
      automatic bit rem = out_ready && (mq.size() > 0);
      if (in_valid && !acc) m_stall++;
      if (rem) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > m_peak) m_peak = mq.size();
    end
  end

  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("cmp_count", 32'(count), 32'(n));
    chk("cmp_empty", 32'(empty), 32'(n == 0));
    chk("cmp_full", 32'(full), 32'(n == 64));
    chk("cmp_almost_full", 32'(almost_full), 32'(n >= 56));
    chk("cmp_in_ready", 32'(in_ready), 32'(n < 64));
    chk("cmp_out_valid", 32'(out_valid), 32'(n > 0));
    chk("cmp_out_data", out_data, (n > 0) ? mq[0] : 32'h0);
`ifdef ROUTER_BUF_STATS_EN
    chk("cmp_peak", 32'(peak_count), 32'(m_peak));
    chk("cmp_stall", stall_cycles, 32'(m_stall));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Fill to full with no drain.
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 56));
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'h40;
    tick();
    chk("refused_count", 32'(count), 32'd64);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("drain_data", out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Steady push/pop at occupancy 10, wrapping both pointers.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'h200 + 32'(i);
      tick();
      chk("steady_count", 32'(count), 32'd10);
    end
    chk("steady_head", out_data, 32'h200 + 32'd90);

    // Build to 30, then flush with a simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h280 + 32'(i);
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd30);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    in_data = 32'h1111;
    tick();
    in_valid = 1'b0;
    chk("post_flush_head", out_data, 32'h1111);
    chk("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset in the middle of a burst.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h300 + 32'(i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd20);
`ifdef ROUTER_BUF_STATS_EN
    chk("pre_rst_peak", 32'(peak_count), 32'd20);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ROUTER_BUF_STATS_EN
    chk("rst_peak", 32'(peak_count), 32'd0);
`endif
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
